// File: rtl/hazard_ctrl_if.sv
// Decode/execute/writeback to hazard-unit bundle.
// The hazard unit takes the slave side; the pipeline stages drive the master side.
interface hazard_ctrl_if #(
    parameter int reg_els_p = 32
);
    localparam int AddrW = $clog2(reg_els_p);

    logic                 decode_hazard_issue_v;
    logic [AddrW-1:0]     decode_hazard_rs1;
    logic                 decode_hazard_rs1_v;
    logic [AddrW-1:0]     decode_hazard_rs2;
    logic                 decode_hazard_rs2_v;
    logic [AddrW-1:0]     decode_hazard_rd;
    logic                 decode_hazard_rd_w_v;
    logic                 writeback_hazard_rd_w_v;
    logic [AddrW-1:0]     writeback_hazard_rd;
    logic                 execute_hazard_pc_w_v;
    logic                 hazard_decode_stall;
    logic                 hazard_flush;
    logic [reg_els_p-1:0] hazard_scoreboard;
    logic [15:0]          hazard_stall_cnt;

    modport master (
        output decode_hazard_issue_v, decode_hazard_rs1, decode_hazard_rs1_v,
               decode_hazard_rs2, decode_hazard_rs2_v, decode_hazard_rd,
               decode_hazard_rd_w_v, writeback_hazard_rd_w_v, writeback_hazard_rd,
               execute_hazard_pc_w_v,
        input  hazard_decode_stall, hazard_flush, hazard_scoreboard, hazard_stall_cnt
    );

    modport slave (
        input  decode_hazard_issue_v, decode_hazard_rs1, decode_hazard_rs1_v,
               decode_hazard_rs2, decode_hazard_rs2_v, decode_hazard_rd,
               decode_hazard_rd_w_v, writeback_hazard_rd_w_v, writeback_hazard_rd,
               execute_hazard_pc_w_v,
        output hazard_decode_stall, hazard_flush, hazard_scoreboard, hazard_stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Scoreboard-based hazard unit: RAW/WAW decode stalls, redirect squash of
// in-flight writers, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int reg_els_p      = 32,
    parameter int squash_depth_p = 2
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int AddrW = $clog2(reg_els_p);
    localparam int CntW  = $clog2(squash_depth_p + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(squash_depth_p);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } hazardStateE;

    hazardStateE            state_q, state_d;
    logic [CntW-1:0]        squashCnt_q, squashCnt_d;
    logic [reg_els_p-1:0]   scoreboard_q, scoreboard_d;
    logic [reg_els_p-1:0]   setMask, wbMask, squashMask;
    logic [squash_depth_p-1:0] histValid_q, histValid_d;
    logic [AddrW-1:0]       histRd_q [squash_depth_p];
    logic [AddrW-1:0]       histRd_d [squash_depth_p];
    logic [15:0]            stallCnt_q, stallCnt_d;

    logic rs1Busy, rs2Busy, rdBusy;
    logic stall, flush, accept, redirect, newWriter;

    // Stall looks only at the registered scoreboard: no write-through bypass exists.
    always_comb begin
        rs1Busy = hz.decode_hazard_rs1_v & scoreboard_q[hz.decode_hazard_rs1];
        rs2Busy = hz.decode_hazard_rs2_v & scoreboard_q[hz.decode_hazard_rs2];
        rdBusy  = hz.decode_hazard_rd_w_v & (hz.decode_hazard_rd != '0)
                  & scoreboard_q[hz.decode_hazard_rd];
        stall   = ~rst & hz.decode_hazard_issue_v & (rs1Busy | rs2Busy | rdBusy);
    end

    always_comb begin
        flush = ~rst & (state_q == SQUASH);
    end

    assign accept    = hz.decode_hazard_issue_v & ~stall & ~flush;
    assign newWriter = accept & hz.decode_hazard_rd_w_v & (hz.decode_hazard_rd != '0);
    assign redirect  = (state_q == RUN) & hz.execute_hazard_pc_w_v;

    always_comb begin
        setMask    = '0;
        wbMask     = '0;
        squashMask = '0;
        if (newWriter)
            setMask[hz.decode_hazard_rd] = 1'b1;
        if (hz.writeback_hazard_rd_w_v && (hz.writeback_hazard_rd != '0))
            wbMask[hz.writeback_hazard_rd] = 1'b1;
        if (redirect) begin
            for (int i = 0; i < squash_depth_p; i++) begin
                if (histValid_q[i])
                    squashMask[histRd_q[i]] = 1'b1;
            end
        end
        // Set beats a writeback clear; a redirect squash beats both.
        scoreboard_d    = ((scoreboard_q & ~wbMask) | setMask) & ~squashMask;
        scoreboard_d[0] = 1'b0;
    end

    always_comb begin
        histValid_d = '0;
        for (int i = 0; i < squash_depth_p; i++)
            histRd_d[i] = '0;
        if (!redirect) begin
            histValid_d[0] = newWriter;
            histRd_d[0]    = hz.decode_hazard_rd;
            for (int i = 1; i < squash_depth_p; i++) begin
                histValid_d[i] = histValid_q[i-1];
                histRd_d[i]    = histRd_q[i-1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        squashCnt_d = squashCnt_q;
        case (state_q)
            RUN: begin
                if (hz.execute_hazard_pc_w_v) begin
                    state_d     = SQUASH;
                    squashCnt_d = CntLoad;
                end
            end
            SQUASH: begin
                if (hz.execute_hazard_pc_w_v) begin
                    squashCnt_d = CntLoad;
                end else if (squashCnt_q == CntW'(1)) begin
                    state_d     = RUN;
                    squashCnt_d = '0;
                end else begin
                    squashCnt_d = squashCnt_q - CntW'(1);
                end
            end
            default: begin
                state_d     = RUN;
                squashCnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall && (stallCnt_q != 16'hFFFF))
            stallCnt_d = stallCnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            squashCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            squashCnt_q <= squashCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scoreboard_q <= '0;
            histValid_q  <= '0;
            stallCnt_q   <= '0;
            for (int i = 0; i < squash_depth_p; i++)
                histRd_q[i] <= '0;
        end else begin
            scoreboard_q <= scoreboard_d;
            histValid_q  <= histValid_d;
            stallCnt_q   <= stallCnt_d;
            for (int i = 0; i < squash_depth_p; i++)
                histRd_q[i] <= histRd_d[i];
        end
    end

    assign hz.hazard_decode_stall = stall;
    assign hz.hazard_flush        = flush;
    assign hz.hazard_scoreboard   = scoreboard_q;
    assign hz.hazard_stall_cnt    = stallCnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RAW/WAW stalls, x0 gating, set/clear
// collision, redirect squash timing, reset abort and counter saturation.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.reg_els_p(32)) hzIf ();

    hazard_ctrl #(
        .reg_els_p      (32),
        .squash_depth_p (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hzIf.slave)
    );

    // One cycle: pass the active edge, drive this cycle's inputs, let them settle.
    task automatic applyStimulus(
        input logic       issue,
        input logic [4:0] rs1, input logic rs1v,
        input logic [4:0] rs2, input logic rs2v,
        input logic [4:0] rd,  input logic rdwv,
        input logic       wbv, input logic [4:0] wbrd,
        input logic       pcwv
    );
        @(posedge clk);
        #1;
        hzIf.decode_hazard_issue_v   = issue;
        hzIf.decode_hazard_rs1       = rs1;
        hzIf.decode_hazard_rs1_v     = rs1v;
        hzIf.decode_hazard_rs2       = rs2;
        hzIf.decode_hazard_rs2_v     = rs2v;
        hzIf.decode_hazard_rd        = rd;
        hzIf.decode_hazard_rd_w_v    = rdwv;
        hzIf.writeback_hazard_rd_w_v = wbv;
        hzIf.writeback_hazard_rd     = wbrd;
        hzIf.execute_hazard_pc_w_v   = pcwv;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        hzIf.decode_hazard_issue_v   = 1'b0;
        hzIf.decode_hazard_rs1       = '0;
        hzIf.decode_hazard_rs1_v     = 1'b0;
        hzIf.decode_hazard_rs2       = '0;
        hzIf.decode_hazard_rs2_v     = 1'b0;
        hzIf.decode_hazard_rd        = '0;
        hzIf.decode_hazard_rd_w_v    = 1'b0;
        hzIf.writeback_hazard_rd_w_v = 1'b0;
        hzIf.writeback_hazard_rd     = '0;
        hzIf.execute_hazard_pc_w_v   = 1'b0;

        idle();
        idle();
        checkOutput("reset_sb",    hzIf.hazard_scoreboard, 32'h0);
        checkOutput("reset_flush", {31'b0, hzIf.hazard_flush}, 32'd0);
        checkOutput("reset_stall", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        checkOutput("reset_cnt",   {16'b0, hzIf.hazard_stall_cnt}, 32'd0);
        rst = 1'b0;

        // RAW on x5, cleared by a writeback with one cycle of visibility delay
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("raw_first_issue", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("raw_sb5",    hzIf.hazard_scoreboard, 32'h0000_0020);
        checkOutput("raw_stall",  {31'b0, hzIf.hazard_decode_stall}, 32'd1);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        checkOutput("raw_stall_wb_cycle", {31'b0, hzIf.hazard_decode_stall}, 32'd1);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("raw_stall_released", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        checkOutput("raw_stall_cnt", {16'b0, hzIf.hazard_stall_cnt}, 32'd2);

        // x0 never becomes busy; unread sources never stall
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("x0_issue_stall", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("x0_sb_empty",   hzIf.hazard_scoreboard, 32'h0);
        checkOutput("x0_read_stall", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("rs2v_sb7",   hzIf.hazard_scoreboard, 32'h0000_0080);
        checkOutput("rs2v_gated", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("rs2_busy_stall", {31'b0, hzIf.hazard_decode_stall}, 32'd1);

        // WAW on x7, writeback retires it
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
        checkOutput("waw_stall", {31'b0, hzIf.hazard_decode_stall}, 32'd1);

        // Accept-set and writeback-clear of x3 in one cycle: set wins
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);
        checkOutput("coll_no_stall", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        checkOutput("coll_cnt", {16'b0, hzIf.hazard_stall_cnt}, 32'd4);
        idle();
        checkOutput("coll_sb3", hzIf.hazard_scoreboard, 32'h0000_0008);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);

        // Redirect squashes x4 and x6, flush lasts two cycles, no accepts meanwhile
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("redir_sb_clean", hzIf.hazard_scoreboard, 32'h0);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("redir_flush_run", {31'b0, hzIf.hazard_flush}, 32'd0);
        checkOutput("redir_sb_before", hzIf.hazard_scoreboard, 32'h0000_0050);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("redir_flush1",   {31'b0, hzIf.hazard_flush}, 32'd1);
        checkOutput("redir_sb_after", hzIf.hazard_scoreboard, 32'h0);
        idle();
        checkOutput("redir_flush2",     {31'b0, hzIf.hazard_flush}, 32'd1);
        checkOutput("redir_no_accept",  hzIf.hazard_scoreboard, 32'h0);
        idle();
        checkOutput("redir_flush_done", {31'b0, hzIf.hazard_flush}, 32'd0);

        // Second redirect during the first flush cycle extends the flush
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("re2_flush1", {31'b0, hzIf.hazard_flush}, 32'd1);
        checkOutput("re2_sb8_squashed", hzIf.hazard_scoreboard, 32'h0);
        idle();
        checkOutput("re2_flush2", {31'b0, hzIf.hazard_flush}, 32'd1);
        idle();
        checkOutput("re2_flush3", {31'b0, hzIf.hazard_flush}, 32'd1);
        idle();
        checkOutput("re2_flush_done", {31'b0, hzIf.hazard_flush}, 32'd0);

        // x10 ages out of the history, so a redirect leaves it busy; reset aborts the squash
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0);
        idle();
        idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        idle();
        checkOutput("old_sb10_kept",  hzIf.hazard_scoreboard, 32'h0000_0400);
        checkOutput("rst_pre_flush",  {31'b0, hzIf.hazard_flush}, 32'd1);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("rst_flush_forced", {31'b0, hzIf.hazard_flush}, 32'd0);
        checkOutput("rst_stall_forced", {31'b0, hzIf.hazard_decode_stall}, 32'd0);
        rst = 1'b0;
        idle();
        checkOutput("rst_sb_cleared", hzIf.hazard_scoreboard, 32'h0);
        checkOutput("rst_flush_run",  {31'b0, hzIf.hazard_flush}, 32'd0);
        checkOutput("rst_cnt_cleared", {16'b0, hzIf.hazard_stall_cnt}, 32'd0);

        // Saturation: hold a RAW stall on x12 well past 65535 cycles
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 65535; i++)
            applyStimulus(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("sat_near", {16'b0, hzIf.hazard_stall_cnt}, 32'd65534);
        applyStimulus(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("sat_reach", {16'b0, hzIf.hazard_stall_cnt}, 32'h0000_FFFF);
        for (int i = 0; i < 4500; i++)
            applyStimulus(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("sat_hold",  {16'b0, hzIf.hazard_stall_cnt}, 32'h0000_FFFF);
        checkOutput("sat_stall", {31'b0, hzIf.hazard_decode_stall}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
